fast_arc_detector: RTL and testbench

- Parametrised successor of the FAST segment-test stage in the feature-detect pipeline.
- Inputs: one centre pixel and its 16 Bresenham-circle neighbours per beat.
- Classifies each neighbour as bright or dark against a runtime threshold and detects a contiguous arc of ARC_LEN same-polarity pixels, with wrap-around.
- Outputs a per-pixel feature flag, an SAD corner score for downstream NMS, and a per-frame feature count. Sits between the circle-window buffer and the NMS block.

---
 rtl/fast_pkg.sv | 25 ++
 rtl/fast_arc_check.sv | 20 ++
 rtl/fast_arc_detector.sv | 162 ++++++++++++++++
 tb/tb_fast_arc_detector.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fast_pkg.sv
// Shared constants and helpers for the FAST segment-test pipeline.
package fast_pkg;

    localparam int N_RING  = 16;
    localparam int ARC_MIN = 9;
    localparam int ARC_MAX = 12;

    // Mask of len consecutive circle positions starting at start, wrapping past 15.
    function automatic logic [N_RING-1:0] ring_mask(input int start, input int len);
        logic [N_RING-1:0] m;
        logic [3:0]        idx;
        m = '0;
        for (int k = 0; k < N_RING; k++) begin
            idx = 4'((start + k) % N_RING);
            if (k < len)
                m[idx] = 1'b1;
        end
        return m;
    endfunction

    function automatic bit arc_len_ok(input int len);
        return (len >= ARC_MIN) && (len <= ARC_MAX);
    endfunction

endpackage

// File: rtl/fast_arc_check.sv
// Flags whether a 16-position class vector holds ARC_LEN contiguous set bits, with wrap.
module fast_arc_check
    import fast_pkg::*;
#(
    parameter int ARC_LEN = 9
) (
    input  logic [N_RING-1:0] cls,
    output logic              any_arc
);

    logic [N_RING-1:0] arc;

    for (genvar s = 0; s < N_RING; s++) begin : g_start
        localparam logic [N_RING-1:0] MASK = ring_mask(s, ARC_LEN);
        assign arc[s] = &(cls | ~MASK);
    end

    assign any_arc = |arc;

endmodule

// File: rtl/fast_arc_detector.sv
// FAST segment test: classify 16 circle neighbours, detect a contiguous arc,
// score by SAD and count features per frame. Four-beat pipeline gated by tvalid_in.
module fast_arc_detector
    import fast_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int ARC_LEN = 9,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tvalid_in,
    input  logic                      in_h_sync,
    input  logic                      in_v_sync,
    input  logic                      in_data_en,
    input  logic [PIX_W-1:0]          threshold,
    input  logic [PIX_W-1:0]          center,
    input  logic [N_RING*PIX_W-1:0]   ring,
    output logic                      o_h_sync,
    output logic                      o_v_sync,
    output logic                      o_data_en,
    output logic                      feature_val,
    output logic                      feature_pol,
    output logic [PIX_W+3:0]          feature_score,
    output logic [N_RING*PIX_W-1:0]   o_abs,
    output logic [CNT_W-1:0]          frame_feat_cnt,
    output logic                      frame_cnt_valid
);

    localparam int LAT = 4;
    localparam int DW  = PIX_W + 1;
    localparam int PW  = PIX_W + 2;
    localparam int SW  = PIX_W + 4;
    localparam logic [PIX_W-1:0] PIX_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    if (!arc_len_ok(ARC_LEN)) begin : g_arc_len_bad
        $error("fast_arc_detector: ARC_LEN %0d outside %0d..%0d", ARC_LEN, ARC_MIN, ARC_MAX);
    end

    logic signed [DW-1:0]  diff_c    [N_RING];
    logic signed [DW-1:0]  s1_diff   [N_RING];
    logic [N_RING-1:0]     bright_c, dark_c;
    logic [PIX_W-1:0]      abs_c     [N_RING];
    logic [N_RING-1:0]     s2_bright, s2_dark;
    logic [PIX_W-1:0]      s2_abs    [N_RING];
    logic                  any_b_c, any_d_c;
    logic [PW-1:0]         part_c    [4];
    logic                  s3_any_b, s3_any_d;
    logic [PW-1:0]         s3_part   [4];
    logic [PIX_W-1:0]      s3_abs    [N_RING];
    logic [SW-1:0]         score_c;
    logic [LAT-1:0]        hs_dl, vs_dl, de_dl;
    logic signed [DW-1:0]  thr_pos, thr_neg;

    assign thr_pos = $signed({1'b0, threshold});
    assign thr_neg = -thr_pos;

    for (genvar i = 0; i < N_RING; i++) begin : g_pix
        assign diff_c[i]   = $signed({1'b0, ring[i*PIX_W +: PIX_W]}) - $signed({1'b0, center});
        assign bright_c[i] = (s1_diff[i] >= thr_pos);
        assign dark_c[i]   = (s1_diff[i] <= thr_neg);
        // Diff never reaches -2^PIX_W, so the low PIX_W bits of the negation are exact.
        assign abs_c[i]    = s1_diff[i][DW-1] ? (~s1_diff[i][PIX_W-1:0] + PIX_ONE)
                                              : s1_diff[i][PIX_W-1:0];
    end

    fast_arc_check #(.ARC_LEN(ARC_LEN)) u_arc_bright (
        .cls     (s2_bright),
        .any_arc (any_b_c)
    );

    fast_arc_check #(.ARC_LEN(ARC_LEN)) u_arc_dark (
        .cls     (s2_dark),
        .any_arc (any_d_c)
    );

    for (genvar j = 0; j < 4; j++) begin : g_part
        assign part_c[j] = PW'(s2_abs[4*j])   + PW'(s2_abs[4*j+1])
                         + PW'(s2_abs[4*j+2]) + PW'(s2_abs[4*j+3]);
    end

    assign score_c = SW'(s3_part[0]) + SW'(s3_part[1]) + SW'(s3_part[2]) + SW'(s3_part[3]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_RING; i++) begin
                s1_diff[i] <= '0;
                s2_abs[i]  <= '0;
                s3_abs[i]  <= '0;
            end
            for (int j = 0; j < 4; j++)
                s3_part[j] <= '0;
            s2_bright     <= '0;
            s2_dark       <= '0;
            s3_any_b      <= 1'b0;
            s3_any_d      <= 1'b0;
            feature_val   <= 1'b0;
            feature_pol   <= 1'b0;
            feature_score <= '0;
            o_abs         <= '0;
            hs_dl         <= '0;
            vs_dl         <= '0;
            de_dl         <= '0;
        end else if (tvalid_in) begin
            for (int i = 0; i < N_RING; i++) begin
                s1_diff[i] <= diff_c[i];
                s2_abs[i]  <= abs_c[i];
                s3_abs[i]  <= s2_abs[i];
                o_abs[i*PIX_W +: PIX_W] <= s3_abs[i];
            end
            for (int j = 0; j < 4; j++)
                s3_part[j] <= part_c[j];
            s2_bright     <= bright_c;
            s2_dark       <= dark_c;
            s3_any_b      <= any_b_c;
            s3_any_d      <= any_d_c;
            feature_val   <= s3_any_b | s3_any_d;
            feature_pol   <= s3_any_b;
            feature_score <= (s3_any_b | s3_any_d) ? score_c : '0;
            hs_dl         <= {hs_dl[LAT-2:0], in_h_sync};
            vs_dl         <= {vs_dl[LAT-2:0], in_v_sync};
            de_dl         <= {de_dl[LAT-2:0], in_data_en};
        end
    end

    assign o_h_sync  = hs_dl[LAT-1];
    assign o_v_sync  = vs_dl[LAT-1];
    assign o_data_en = de_dl[LAT-1];

    logic             vs_prev;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] run_inc;
    logic             hit;
    logic             v_edge;

    assign hit     = o_data_en & feature_val;
    assign v_edge  = o_v_sync & ~vs_prev;
    assign run_inc = (&run_cnt) ? run_cnt : run_cnt + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev         <= 1'b0;
            run_cnt         <= '0;
            frame_feat_cnt  <= '0;
            frame_cnt_valid <= 1'b0;
        end else begin
            frame_cnt_valid <= 1'b0;
            if (tvalid_in) begin
                vs_prev <= o_v_sync;
                if (v_edge) begin
                    frame_feat_cnt  <= run_cnt;
                    frame_cnt_valid <= 1'b1;
                    run_cnt         <= hit ? CNT_ONE : '0;
                end else if (hit) begin
                    run_cnt <= run_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_fast_arc_detector.sv
// Directed bench for fast_arc_detector: default build plus an ARC_LEN=12, CNT_W=4 build.
module tb_fast_arc_detector;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tvalid_in;
    logic         in_h_sync, in_v_sync, in_data_en;
    logic [7:0]   threshold, center;
    logic [127:0] ring;

    logic         oh_a, ov_a, ode_a, fv_a, fp_a, fcv_a;
    logic [11:0]  fs_a;
    logic [127:0] abs_a;
    logic [15:0]  fc_a;
    logic         oh_b, ov_b, ode_b, fv_b, fp_b, fcv_b;
    logic [11:0]  fs_b;
    logic [127:0] abs_b;
    logic [3:0]   fc_b;

    fast_arc_detector dut (
        .clk(clk), .rst_n(rst_n), .tvalid_in(tvalid_in),
        .in_h_sync(in_h_sync), .in_v_sync(in_v_sync), .in_data_en(in_data_en),
        .threshold(threshold), .center(center), .ring(ring),
        .o_h_sync(oh_a), .o_v_sync(ov_a), .o_data_en(ode_a),
        .feature_val(fv_a), .feature_pol(fp_a), .feature_score(fs_a), .o_abs(abs_a),
        .frame_feat_cnt(fc_a), .frame_cnt_valid(fcv_a)
    );

    fast_arc_detector #(.ARC_LEN(12), .CNT_W(4)) dut12 (
        .clk(clk), .rst_n(rst_n), .tvalid_in(tvalid_in),
        .in_h_sync(in_h_sync), .in_v_sync(in_v_sync), .in_data_en(in_data_en),
        .threshold(threshold), .center(center), .ring(ring),
        .o_h_sync(oh_b), .o_v_sync(ov_b), .o_data_en(ode_b),
        .feature_val(fv_b), .feature_pol(fp_b), .feature_score(fs_b), .o_abs(abs_b),
        .frame_feat_cnt(fc_b), .frame_cnt_valid(fcv_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  c, va, vb, vx, thr;
        logic [15:0] mask;
        int          xi;
        logic [2:0]  sync;
        logic        ev, ep;
        int          es, ai, ea;
        logic        ev12;
    } vec_t;

    localparam int NV = 12;
    vec_t tv [NV];
    vec_t blank;
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [7:0] c, va, vb, thr, input logic [15:0] mask,
                                input int xi, input logic [7:0] vx, input logic [2:0] sync,
                                input logic ev, ep, input int es, ai, ea, input logic ev12);
        vec_t v;
        v.c = c; v.va = va; v.vb = vb; v.thr = thr; v.mask = mask; v.xi = xi; v.vx = vx;
        v.sync = sync; v.ev = ev; v.ep = ep; v.es = es; v.ai = ai; v.ea = ea; v.ev12 = ev12;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Pixel data and syncs only; threshold is presented one beat later.
    task automatic drive(input vec_t v);
        center = v.c;
        for (int i = 0; i < 16; i++)
            ring[i*8 +: 8] = (i == v.xi) ? v.vx : (v.mask[i] ? v.va : v.vb);
        {in_h_sync, in_v_sync, in_data_en} = v.sync;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    int stall_pat [9] = '{0, 0, 1, 0, 1, 0, 1, 0, 1};
    int fr_feat   [9] = '{1, 0, 1, 1, 1, 1, 0, 1, 0};
    int fr_de     [9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
    int fr_vs     [9] = '{0, 0, 0, 0, 0, 1, 0, 0, 1};

    initial begin
        //          c    va   vb   thr mask     xi  vx  sync   ev pol score ai ea   ev12
        tv[0]  = mk(100, 170, 100, 60, 16'h01FF, -1, 0,  3'b001, 1, 1, 630,  0, 70,  0);
        tv[1]  = mk(100, 20,  100, 50, 16'hF01F, -1, 0,  3'b100, 1, 0, 720,  0, 80,  0);
        tv[2]  = mk(100, 20,  100, 50, 16'hF01F,  4, 60, 3'b010, 0, 0, 0,    4, 40,  0);
        tv[3]  = mk(50,  50,  50,  0,  16'h0000, -1, 0,  3'b111, 1, 1, 0,    7, 0,   1);
        tv[4]  = mk(100, 200, 100, 60, 16'h00FF, -1, 0,  3'b000, 0, 0, 0,    3, 100, 0);
        tv[5]  = mk(0,   255, 255, 255,16'hFFFF, -1, 0,  3'b101, 1, 1, 4080, 15, 255, 1);
        tv[6]  = mk(255, 0,   0,   255,16'hFFFF, -1, 0,  3'b011, 1, 0, 4080, 8, 255, 1);
        tv[7]  = mk(100, 160, 100, 60, 16'h01FF, -1, 0,  3'b110, 1, 1, 540,  8, 60,  0);
        tv[8]  = mk(100, 159, 100, 60, 16'h01FF, -1, 0,  3'b001, 0, 0, 0,    0, 59,  0);
        tv[9]  = mk(100, 40,  100, 60, 16'h0FF8, -1, 0,  3'b010, 1, 0, 540,  11, 60, 0);
        tv[10] = mk(100, 180, 100, 60, 16'h07FF, -1, 0,  3'b100, 1, 1, 880,  10, 80, 0);
        tv[11] = mk(100, 180, 100, 60, 16'hFC3F, -1, 0,  3'b111, 1, 1, 960,  15, 80, 1);
        blank  = mk(100, 100, 100, 60, 16'h0000, -1, 0,  3'b000, 0, 0, 0,    0, 0,   0);

        rst_n = 1'b0;
        tvalid_in = 1'b0;
        threshold = 8'd60;
        drive(blank);
        #12;
        chk("rst feature_val", {31'd0, fv_a}, 0);
        chk("rst feature_score", {20'd0, fs_a}, 0);
        chk("rst o_abs", {31'd0, |abs_a}, 0);
        chk("rst syncs", {29'd0, oh_a, ov_a, ode_a}, 0);
        chk("rst frame_feat_cnt", {16'd0, fc_a}, 0);
        chk("rst frame_cnt_valid", {31'd0, fcv_a}, 0);
        rst_n = 1'b1;
        tick();

        // Back-to-back vector stream: beat k is visible after edge k+3.
        tvalid_in = 1'b1;
        for (int k = 0; k < NV + 3; k++) begin
            if (k < NV) drive(tv[k]); else drive(blank);
            threshold = (k >= 1 && k <= NV) ? tv[k-1].thr : 8'd60;
            tick();
            if (k >= 3) begin
                vec_t e;
                e = tv[k-3];
                chk($sformatf("v%0d val", k-3), {31'd0, fv_a}, {31'd0, e.ev});
                chk($sformatf("v%0d pol", k-3), {31'd0, fp_a}, {31'd0, e.ep});
                chk($sformatf("v%0d score", k-3), {20'd0, fs_a}, e.es);
                chk($sformatf("v%0d abs[%0d]", k-3, e.ai), {24'd0, abs_a[e.ai*8 +: 8]}, e.ea);
                chk($sformatf("v%0d syncs", k-3), {29'd0, oh_a, ov_a, ode_a}, {29'd0, e.sync});
                chk($sformatf("v%0d val arc12", k-3), {31'd0, fv_b}, {31'd0, e.ev12});
            end
        end

        // Stall: a marked beat must surface on exactly the fourth advancing edge.
        do_reset();
        threshold = 8'd60;
        drive(tv[0]);
        {in_h_sync, in_v_sync, in_data_en} = 3'b011;
        tvalid_in = 1'b1;
        tick();
        drive(blank);
        begin
            int adv;
            adv = 1;
            for (int k = 0; k < 9; k++) begin
                tvalid_in = stall_pat[k][0];
                tick();
                if (stall_pat[k] != 0) adv++;
                chk($sformatf("stall%0d val", k), {31'd0, fv_a}, (adv == 4) ? 1 : 0);
                chk($sformatf("stall%0d score", k), {20'd0, fs_a}, (adv == 4) ? 630 : 0);
                chk($sformatf("stall%0d v_sync", k), {31'd0, ov_a}, (adv == 4) ? 1 : 0);
                chk($sformatf("stall%0d data_en", k), {31'd0, ode_a}, (adv == 4) ? 1 : 0);
                chk($sformatf("stall%0d cnt_valid", k), {31'd0, fcv_a}, (k == 8) ? 1 : 0);
            end
        end

        // Frame count: 3 counted features, then an edge beat that itself holds a feature.
        do_reset();
        tvalid_in = 1'b1;
        threshold = 8'd60;
        for (int k = 0; k < 14; k++) begin
            if (k < 9) begin
                drive(fr_feat[k] != 0 ? tv[0] : blank);
                {in_h_sync, in_v_sync, in_data_en} = {1'b0, fr_vs[k][0], fr_de[k][0]};
            end else begin
                drive(blank);
            end
            tick();
            chk($sformatf("frame edge%0d cnt_valid", k), {31'd0, fcv_a},
                (k == 9 || k == 12) ? 1 : 0);
            if (k == 9)  chk("frame1 count", {16'd0, fc_a}, 3);
            if (k == 12) chk("frame2 count", {16'd0, fc_a}, 2);
        end

        // Saturation: 20 features into a 4-bit counter.
        do_reset();
        tvalid_in = 1'b1;
        threshold = 8'd255;
        for (int k = 0; k < 20; k++) begin
            drive(tv[5]);
            {in_h_sync, in_v_sync, in_data_en} = 3'b001;
            tick();
        end
        drive(blank);
        {in_h_sync, in_v_sync, in_data_en} = 3'b011;
        tick();
        drive(blank);
        begin
            logic got;
            got = 1'b0;
            for (int k = 0; k < 12 && !got; k++) begin
                tick();
                if (fcv_b) begin
                    got = 1'b1;
                    chk("sat count cnt4", {28'd0, fc_b}, 15);
                    chk("sat count cnt16", {16'd0, fc_a}, 20);
                end
            end
            chk("sat pulse seen", {31'd0, got}, 1);
        end

        // Asynchronous reset in the middle of a frame.
        for (int k = 0; k < 5; k++) begin
            drive(tv[5]);
            {in_h_sync, in_v_sync, in_data_en} = 3'b111;
            tick();
        end
        chk("pre-rst val", {31'd0, fv_a}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst val", {30'd0, fv_a, fv_b}, 0);
        chk("async rst score", {20'd0, fs_a}, 0);
        chk("async rst o_abs", {31'd0, |abs_a}, 0);
        chk("async rst syncs", {29'd0, oh_a, ov_a, ode_a}, 0);
        chk("async rst count", {12'd0, fc_a, fc_b}, 0);
        rst_n = 1'b1;
        tvalid_in = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
